data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the core's memory-stage load/store interface.
- Receives the request that the pipeline's memory stage presents (address, write data, write enable) and services it from a local word-addressed RAM after a programmable number of wait states.
- Holds the pipeline with a stall until the access completes.
- Its stall output feeds the hazard unit, which ORs it into the global stall.

Parameters:
- DATA_WIDTH, 32, width of the data word.
- ADDRESS_WIDTH, 32, width of the byte address from the memory stage.
- MEM_DEPTH, 256, number of words in the RAM; must be a power of two.
- WAIT_STATES, 2, extra latency cycles per access; legal range 0..15.

Ports:
- i_CLK  in  1  clock; all state changes on rising edge.
- i_RST  in  1  synchronous, active-high reset.
- i_ReqM  in  1  access request valid (load or store in memory stage).
- i_WeM  in  1  1 = store, 0 = load; sampled with i_ReqM.
- i_AddrM  in  ADDRESS_WIDTH  byte address.
- i_WDataM  in  DATA_WIDTH  store data.
- o_RDataM  out  DATA_WIDTH  load data, registered.
- o_StallM  out  1  hold the pipeline (combinational).
- o_AckM  out  1  one-cycle completion pulse, registered.
- o_AddrErrM  out  1  misaligned-access flag, valid with o_AckM.

Behaviour:
- Clock and reset: one clock, i_CLK. Reset i_RST is synchronous and active-high.
- Reset values: state=IDLE, counter=0, o_RDataM=0, o_AckM=0, o_AddrErrM=0, latched request=0. RAM contents are not reset.
- Word index = i_AddrM[log2(MEM_DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo MEM_DEPTH*4.
- Misaligned access is i_AddrM[1:0]!=0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If i_ReqM=1, latch we/addr/wdata and load counter=WAIT_STATES.
  - If the access is misaligned, or WAIT_STATES=0, go to DONE; otherwise go to WAIT.
- WAIT:
  - Decrement counter each cycle.
  - When counter==1, go to DONE. WAIT therefore lasts exactly WAIT_STATES cycles.
- Edge entering DONE:
  - Store (aligned): RAM[index] <= latched wdata; o_RDataM <= 0.
  - Load (aligned): o_RDataM <= RAM[index].
  - Misaligned: no RAM write; o_RDataM <= 0; o_AddrErrM <= 1.
  - o_AckM <= 1 in all cases.
- DONE:
  - o_AckM=1 for exactly this cycle.
  - Go to IDLE unconditionally. i_ReqM is ignored here because it still belongs to the completing instruction.
- Leaving DONE: o_AckM <= 0 and o_AddrErrM <= 0. o_RDataM holds its value until the next DONE entry.
- Stall: o_StallM = (state==IDLE & i_ReqM) | (state==WAIT). It is low in DONE so the pipeline advances at the end of that cycle.
- Stall cycles per access = 1 + WAIT_STATES. Misaligned accesses always take 1 stall cycle.
- Back-to-back requests: the next instruction arrives in the memory stage in the cycle after DONE, when the FSM is in IDLE. It is serviced with no idle gap.
- If i_ReqM drops during WAIT (illegal while stalled), the latched transaction still completes normally.
- Reset in WAIT: the FSM returns to IDLE and no RAM write occurs, because the write commits only on DONE entry.
- Reset in DONE: the write already committed stays; o_AckM clears on the reset edge.
- Store followed by a load to the same address returns the new data. The write commits before the load latches.

Test Plan:
- Reset: hold i_RST 2 cycles with i_ReqM=1 -> o_StallM=1 only via IDLE&i_ReqM; o_AckM=0, o_RDataM=0; after release the FSM starts from IDLE.
- WAIT_STATES=2: store 0xDEADBEEF @0x10, then load @0x10 -> each access has o_StallM high 3 cycles, then one o_AckM pulse; load o_RDataM=0xDEADBEEF.
- WAIT_STATES=0: back-to-back stores 0x1,0x2 @0x0,0x4, then loads -> 1 stall cycle each, no idle gap, reads return 0x1, 0x2.
- Misaligned load @0x13 -> 1 stall cycle; o_AckM=1 and o_AddrErrM=1 together; o_RDataM=0; RAM unchanged (verified by a reread).
- Reset asserted in the 2nd WAIT cycle of a store 0x55 @0x20 -> after reset, a load @0x20 returns the prior value, not 0x55.
- MEM_DEPTH=256: store 0xA5 @0x400 -> load @0x0 returns 0xA5 (wrap).

Source files
------------

// File: rtl/data_mem_responder.sv
// Memory-stage load/store responder: services one request at a time from a local
// word-addressed RAM after WAIT_STATES extra cycles, stalling the pipeline until done.
module data_mem_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_DEPTH     = 256,
  parameter int WAIT_STATES   = 2
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_ReqM,
  input  logic                     i_WeM,
  input  logic [ADDRESS_WIDTH-1:0] i_AddrM,
  input  logic [DATA_WIDTH-1:0]    i_WDataM,
  output logic [DATA_WIDTH-1:0]    o_RDataM,
  output logic                     o_StallM,
  output logic                     o_AckM,
  output logic                     o_AddrErrM
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

  stateT                  state;
  logic [3:0]             waitCnt;
  logic                   latWe;
  logic                   latMis;
  logic [IDX_W-1:0]       latIdx;
  logic [DATA_WIDTH-1:0]  latWData;

  logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

  logic [IDX_W-1:0]       reqIdx;
  logic                   reqMis;
  logic                   txWe;
  logic                   txMis;
  logic [IDX_W-1:0]       txIdx;
  logic [DATA_WIDTH-1:0]  txWData;
  logic                   goDone;
  logic                   doWrite;
  logic                   unusedAddrBits;

  assign reqIdx = i_AddrM[IDX_W+1:2];
  assign reqMis = |i_AddrM[1:0];
  assign unusedAddrBits = ^i_AddrM[ADDRESS_WIDTH-1:IDX_W+2];

  // A request that completes straight from IDLE uses the live inputs, since the
  // latch is being loaded on the same edge.
  always_comb begin
    txWe    = latWe;
    txMis   = latMis;
    txIdx   = latIdx;
    txWData = latWData;
    if (state == IDLE) begin
      txWe    = i_WeM;
      txMis   = reqMis;
      txIdx   = reqIdx;
      txWData = i_WDataM;
    end
  end

  assign goDone  = ((state == IDLE) && i_ReqM && (reqMis || (WAIT_STATES == 0))) ||
                   ((state == WAIT) && (waitCnt == 4'd1));
  assign doWrite = goDone && !txMis && txWe;

  assign o_StallM = ((state == IDLE) && i_ReqM) || (state == WAIT);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state      <= IDLE;
      waitCnt    <= '0;
      latWe      <= 1'b0;
      latMis     <= 1'b0;
      latIdx     <= '0;
      latWData   <= '0;
      o_RDataM   <= '0;
      o_AckM     <= 1'b0;
      o_AddrErrM <= 1'b0;
    end else begin
      o_AckM     <= goDone;
      o_AddrErrM <= goDone && txMis;
      if (goDone)
        o_RDataM <= (txMis || txWe) ? '0 : mem[txIdx];
      case (state)
        IDLE: begin
          if (i_ReqM) begin
            latWe    <= i_WeM;
            latMis   <= reqMis;
            latIdx   <= reqIdx;
            latWData <= i_WDataM;
            waitCnt  <= 4'(WAIT_STATES);
            state    <= goDone ? DONE : WAIT;
          end
        end
        WAIT: begin
          waitCnt <= waitCnt - 4'd1;
          if (waitCnt == 4'd1)
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The write commits only on the DONE-entry edge, so a reset while waiting drops it.
  always_ff @(posedge i_CLK) begin
    if (!i_RST && doWrite)
      mem[txIdx] <= txWData;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (WAIT_STATES=2 and 0) driven by
// directed scenarios and random traffic, checked against an array-based memory model.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic        ack   [2];
  logic        err   [2];

  int errors = 0;
  int checks = 0;

  logic [31:0] modelMem [2][256];
  bit          known    [2][256];

  data_mem_responder #(.WAIT_STATES(2)) dut0 (
    .i_CLK(clk), .i_RST(rst), .i_ReqM(req[0]), .i_WeM(we[0]), .i_AddrM(addr[0]),
    .i_WDataM(wdata[0]), .o_RDataM(rdata[0]), .o_StallM(stall[0]), .o_AckM(ack[0]),
    .o_AddrErrM(err[0])
  );

  data_mem_responder #(.WAIT_STATES(0)) dut1 (
    .i_CLK(clk), .i_RST(rst), .i_ReqM(req[1]), .i_WeM(we[1]), .i_AddrM(addr[1]),
    .i_WDataM(wdata[1]), .o_RDataM(rdata[1]), .o_StallM(stall[1]), .o_AckM(ack[1]),
    .o_AddrErrM(err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int wsOf(input int inst);
    return (inst == 0) ? 2 : 0;
  endfunction

  // Presents one request while the FSM is idle, counts stall cycles up to the
  // completion cycle, captures the outputs there, then returns in the next (idle) cycle.
  task automatic doAccess(input int inst, input bit w, input logic [31:0] a,
                          input logic [31:0] d, output int stalls, output logic ackO,
                          output logic errO, output logic [31:0] rd);
    req[inst] = 1'b1; we[inst] = w; addr[inst] = a; wdata[inst] = d;
    #1;
    stalls = 0;
    while (stall[inst] === 1'b1 && stalls < 40) begin
      stalls++;
      @(posedge clk); #1;
    end
    ackO = ack[inst]; errO = err[inst]; rd = rdata[inst];
    req[inst] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req[0] = 1'b1; req[1] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        checks++; if (stall[i] !== 1'b1) begin errors++; $display("FAIL reset_stall inst=%0d got=%b exp=1", i, stall[i]); end
        checks++; if (ack[i] !== 1'b0) begin errors++; $display("FAIL reset_ack inst=%0d got=%b exp=0", i, ack[i]); end
        checks++; if (rdata[i] !== 32'h0) begin errors++; $display("FAIL reset_rdata inst=%0d got=%h exp=0", i, rdata[i]); end
        checks++; if (err[i] !== 1'b0) begin errors++; $display("FAIL reset_err inst=%0d got=%b exp=0", i, err[i]); end
      end
    end
    req[0] = 1'b0; req[1] = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (stall[i] !== 1'b0) begin errors++; $display("FAIL post_reset_idle inst=%0d got=%b exp=0", i, stall[i]); end
    end
  endtask

  task automatic test_wait2;
    int st; logic a, e; logic [31:0] rd;
    doAccess(0, 1'b1, 32'h10, 32'hDEADBEEF, st, a, e, rd);
    modelMem[0][4] = 32'hDEADBEEF; known[0][4] = 1'b1;
    checks++; if (st !== 3) begin errors++; $display("FAIL wait2_store_stall got=%0d exp=3", st); end
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL wait2_store_ack got=%b exp=1", a); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wait2_store_rdata got=%h exp=0", rd); end
    checks++; if (ack[0] !== 1'b0) begin errors++; $display("FAIL wait2_ack_pulse got=%b exp=0", ack[0]); end
    doAccess(0, 1'b0, 32'h10, 32'h0, st, a, e, rd);
    checks++; if (st !== 3) begin errors++; $display("FAIL wait2_load_stall got=%0d exp=3", st); end
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL wait2_load_ack got=%b exp=1", a); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wait2_load_rdata got=%h exp=deadbeef", rd); end
    checks++; if (rdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wait2_rdata_hold got=%h exp=deadbeef", rdata[0]); end
  endtask

  task automatic test_back_to_back;
    int st; logic a, e; logic [31:0] rd;
    logic [31:0] ad [4]; logic [31:0] dv [4]; bit wv [4];
    ad = '{32'h0, 32'h4, 32'h0, 32'h4};
    dv = '{32'h1, 32'h2, 32'h0, 32'h0};
    wv = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      doAccess(1, wv[k], ad[k], dv[k], st, a, e, rd);
      checks++; if (st !== 1) begin errors++; $display("FAIL b2b_stall k=%0d got=%0d exp=1", k, st); end
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL b2b_ack k=%0d got=%b exp=1", k, a); end
      if (!wv[k]) begin
        checks++; if (rd !== (k == 2 ? 32'h1 : 32'h2)) begin errors++; $display("FAIL b2b_rdata k=%0d got=%h exp=%h", k, rd, (k == 2 ? 32'h1 : 32'h2)); end
      end
    end
    modelMem[1][0] = 32'h1; known[1][0] = 1'b1;
    modelMem[1][1] = 32'h2; known[1][1] = 1'b1;
  endtask

  task automatic test_misaligned;
    int st; logic a, e; logic [31:0] rd;
    doAccess(0, 1'b0, 32'h13, 32'h0, st, a, e, rd);
    checks++; if (st !== 1) begin errors++; $display("FAIL mis_load_stall got=%0d exp=1", st); end
    checks++; if (a !== 1'b1 || e !== 1'b1) begin errors++; $display("FAIL mis_load_ackerr got=%b%b exp=11", a, e); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_load_rdata got=%h exp=0", rd); end
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL mis_err_clear got=%b exp=0", err[0]); end
    doAccess(0, 1'b1, 32'h11, 32'hBAD0BAD0, st, a, e, rd);
    checks++; if (st !== 1 || e !== 1'b1) begin errors++; $display("FAIL mis_store got stall=%0d err=%b exp stall=1 err=1", st, e); end
    doAccess(0, 1'b0, 32'h10, 32'h0, st, a, e, rd);
    checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL mis_reread got=%h err=%b exp=deadbeef err=0", rd, e); end
  endtask

  task automatic test_reset_in_wait;
    int st; logic a, e; logic [31:0] rd;
    doAccess(0, 1'b1, 32'h20, 32'h77, st, a, e, rd);
    modelMem[0][8] = 32'h77; known[0][8] = 1'b1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h55;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (stall[0] !== 1'b1 || ack[0] !== 1'b0) begin errors++; $display("FAIL rstwait_in_wait stall=%b ack=%b exp stall=1 ack=0", stall[0], ack[0]); end
    rst = 1'b1; req[0] = 1'b0;
    @(posedge clk); #1;
    checks++; if (stall[0] !== 1'b0 || ack[0] !== 1'b0) begin errors++; $display("FAIL rstwait_after stall=%b ack=%b exp 0 0", stall[0], ack[0]); end
    rst = 1'b0;
    doAccess(0, 1'b0, 32'h20, 32'h0, st, a, e, rd);
    checks++; if (rd !== 32'h77) begin errors++; $display("FAIL rstwait_reread got=%h exp=77", rd); end
    checks++; if (st !== 3) begin errors++; $display("FAIL rstwait_stall got=%0d exp=3", st); end
  endtask

  task automatic test_wrap;
    int st; logic a, e; logic [31:0] rd;
    doAccess(0, 1'b1, 32'h400, 32'hA5, st, a, e, rd);
    modelMem[0][0] = 32'hA5; known[0][0] = 1'b1;
    doAccess(0, 1'b0, 32'h0, 32'h0, st, a, e, rd);
    checks++; if (rd !== 32'hA5) begin errors++; $display("FAIL wrap_read got=%h exp=a5", rd); end
  endtask

  task automatic test_random(input int inst, input int n);
    int st; logic a, e; logic [31:0] rd;
    bit w, mis; logic [31:0] ad, d, expRd; int idx, expSt;
    for (int k = 0; k < n; k++) begin
      w  = 1'($urandom_range(0, 1));
      ad = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3)) * 1024;
      if ($urandom_range(0, 4) == 0) ad = ad + 32'($urandom_range(1, 3));
      d  = $urandom;
      idx = int'((ad / 4) % 256);
      mis = (ad % 4) != 0;
      expSt = mis ? 1 : 1 + wsOf(inst);
      expRd = (mis || w) ? 32'h0 : modelMem[inst][idx];
      doAccess(inst, w, ad, d, st, a, e, rd);
      checks++; if (st !== expSt || a !== 1'b1 || e !== mis) begin
        errors++; $display("FAIL rand_ctrl inst=%0d k=%0d stall=%0d ack=%b err=%b exp stall=%0d ack=1 err=%b", inst, k, st, a, e, expSt, mis);
      end
      if (mis || w || known[inst][idx]) begin
        checks++; if (rd !== expRd) begin errors++; $display("FAIL rand_rdata inst=%0d k=%0d addr=%h got=%h exp=%h", inst, k, ad, rd, expRd); end
      end
      if (w && !mis) begin modelMem[inst][idx] = d; known[inst][idx] = 1'b1; end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0;
      for (int j = 0; j < 256; j++) begin modelMem[i][j] = 32'h0; known[i][j] = 1'b0; end
    end
    test_reset();
    test_wait2();
    test_back_to_back();
    test_misaligned();
    test_reset_in_wait();
    test_wrap();
    test_random(0, 30);
    test_random(1, 30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
